// File: rtl/timer_pkg.sv
// timer_pkg: shared BCD digit type and digit limits for the MM:SS timer.
package timer_pkg;
  localparam int BCD_W = 4;
  typedef logic [BCD_W-1:0] bcd_t;
  localparam bcd_t DIGIT_MAX = 4'd9;
  localparam bcd_t SEC_TENS_MAX = 4'd5;
endpackage

// File: rtl/bcd_down_digit.sv
// bcd_down_digit: one loadable BCD down-counting digit with borrow chaining.
module bcd_down_digit
  import timer_pkg::*;
#(
  parameter bcd_t WRAP_VAL = DIGIT_MAX
) (
  input  logic clk,
  input  logic clearn,
  input  logic load_en,
  input  bcd_t load_val,
  input  logic dec_en,
  input  logic borrow_in,
  output bcd_t digit,
  output logic borrow_out
);
  bcd_t r_digit;
  always_ff @(posedge clk or negedge clearn)
    if (!clearn) r_digit <= '0;
    else if (load_en) r_digit <= load_val;
    else if (dec_en && borrow_in) r_digit <= (r_digit == '0) ? WRAP_VAL : r_digit - 4'd1;
  assign digit = r_digit;
  assign borrow_out = (r_digit == '0) && borrow_in;
endmodule

// File: rtl/countdown_timer_mmss.sv
// countdown_timer_mmss: keypad-loaded MM:SS BCD countdown with zero detect and done pulse.
module countdown_timer_mmss
  import timer_pkg::*;
#(
  parameter bcd_t SEC_TENS_MAX = timer_pkg::SEC_TENS_MAX,
  parameter bcd_t DIGIT_MAX = timer_pkg::DIGIT_MAX
) (
  input  logic clk,
  input  logic clearn,
  input  bcd_t d,
  input  logic loadn,
  input  logic pgt_1Hz,
  input  logic enablen,
  output bcd_t min_tens,
  output bcd_t min_ones,
  output bcd_t sec_tens,
  output bcd_t sec_ones,
  output logic zero,
  output logic done
);
  bcd_t [3:0] w_digit;
  bcd_t [3:0] w_shift;
  logic [4:0] w_borrow;
  logic w_load, w_dec, w_one;
  logic r_done;
  assign w_load = enablen && !loadn && (d <= DIGIT_MAX);
  assign w_dec = !enablen && pgt_1Hz && !zero;
  assign w_shift = {w_digit[2:0], d};
  // Borrow enters sec_ones unconditionally, so a borrow out of min_tens means all digits are zero.
  assign w_borrow[0] = 1'b1;
  assign zero = w_borrow[4];
  assign w_one = (w_digit[3:1] == '0) && (w_digit[0] == 4'd1);
  genvar i;
  for (i = 0; i < 4; i++) begin : g_dig
    bcd_down_digit #(
      .WRAP_VAL((i == 1) ? SEC_TENS_MAX : DIGIT_MAX)
    ) u_dig (
      .clk(clk),
      .clearn(clearn),
      .load_en(w_load),
      .load_val(w_shift[i]),
      .dec_en(w_dec),
      .borrow_in(w_borrow[i]),
      .digit(w_digit[i]),
      .borrow_out(w_borrow[i+1])
    );
  end
  always_ff @(posedge clk or negedge clearn)
    if (!clearn) r_done <= 1'b0;
    else r_done <= w_dec && w_one;
  assign {min_tens, min_ones, sec_tens, sec_ones} = w_digit;
  assign done = r_done;
endmodule

// File: tb/tb_countdown_timer_mmss.sv
// tb_countdown_timer_mmss: vector table, directed corner cases and random run against an MM:SS model.
module tb_countdown_timer_mmss;
  logic clk = 1'b0;
  logic clearn = 1'b0;
  logic [3:0] d = '0;
  logic loadn = 1'b1;
  logic pgt_1Hz = 1'b0;
  logic enablen = 1'b1;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
  logic zero, done;
  int n_checks = 0;
  int n_fail = 0;
  int mm, ss;
  logic m_done;

  countdown_timer_mmss dut (
    .clk(clk), .clearn(clearn), .d(d), .loadn(loadn), .pgt_1Hz(pgt_1Hz),
    .enablen(enablen), .min_tens(min_tens), .min_ones(min_ones),
    .sec_tens(sec_tens), .sec_ones(sec_ones), .zero(zero), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic ld;
    logic [3:0] dd;
    logic tk;
    logic en;
    logic [15:0] e;
    logic ed;
  } vec_t;
  vec_t tv[$];

  task automatic chk(input string nm, input logic [15:0] e, input logic ed);
    logic [15:0] a;
    a = {min_tens, min_ones, sec_tens, sec_ones};
    n_checks++;
    if (a !== e || zero !== (e == 16'h0) || done !== ed) begin
      n_fail++;
      $display("FAIL %s: got %h zero=%b done=%b, expected %h zero=%b done=%b",
               nm, a, zero, done, e, (e == 16'h0), ed);
    end
  endtask

  task automatic cyc(input logic ld, input logic [3:0] dd, input logic tk, input logic en);
    loadn = ld; d = dd; pgt_1Hz = tk; enablen = en;
    @(posedge clk);
    #1;
    loadn = 1'b1; pgt_1Hz = 1'b0;
  endtask

  task automatic load4(input logic [15:0] v);
    for (int k = 3; k >= 0; k--) cyc(1'b0, v[k*4 +: 4], 1'b0, 1'b1);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3 clearn = 1'b0;
    #1;
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1 clearn = 1'b1;
  endtask

  // Model holds minutes and seconds as integers; entry treats MMSS as a 4-digit decimal number.
  task automatic m_step(input logic ld, input logic [3:0] dd, input logic tk, input logic en);
    int v;
    m_done = 1'b0;
    if (en) begin
      if (!ld && dd <= 9) begin
        v = ((mm * 100 + ss) * 10 + int'(dd)) % 10000;
        mm = v / 100;
        ss = v % 100;
      end
    end else if (tk && !(mm == 0 && ss == 0)) begin
      m_done = (mm == 0 && ss == 1);
      if (ss == 0) begin
        ss = 59;
        mm--;
      end else ss--;
    end
  endtask

  function automatic logic [15:0] m_val();
    m_val = {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
  endfunction

  initial begin
    logic ld, tk, en;
    logic [3:0] dd;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_hold", 16'h0000, 1'b0);
    clearn = 1'b1;
    #1;
    chk("reset_release", 16'h0000, 1'b0);

    tv.push_back('{1'b0, 4'd1, 1'b0, 1'b1, 16'h0001, 1'b0});
    tv.push_back('{1'b0, 4'd3, 1'b0, 1'b1, 16'h0013, 1'b0});
    tv.push_back('{1'b0, 4'd0, 1'b0, 1'b1, 16'h0130, 1'b0});
    tv.push_back('{1'b0, 4'hA, 1'b0, 1'b1, 16'h0130, 1'b0});
    tv.push_back('{1'b0, 4'hF, 1'b0, 1'b1, 16'h0130, 1'b0});
    tv.push_back('{1'b0, 4'd2, 1'b0, 1'b1, 16'h1302, 1'b0});
    tv.push_back('{1'b0, 4'd4, 1'b0, 1'b1, 16'h3024, 1'b0});
    tv.push_back('{1'b0, 4'd5, 1'b0, 1'b0, 16'h3024, 1'b0});
    tv.push_back('{1'b1, 4'd0, 1'b1, 1'b0, 16'h3023, 1'b0});
    tv.push_back('{1'b1, 4'd0, 1'b1, 1'b1, 16'h3023, 1'b0});
    tv.push_back('{1'b0, 4'd7, 1'b1, 1'b1, 16'h0237, 1'b0});
    tv.push_back('{1'b0, 4'd1, 1'b1, 1'b0, 16'h0236, 1'b0});
    tv.push_back('{1'b1, 4'd0, 1'b0, 1'b0, 16'h0236, 1'b0});
    foreach (tv[k]) begin
      cyc(tv[k].ld, tv[k].dd, tv[k].tk, tv[k].en);
      chk($sformatf("vec%0d", k), tv[k].e, tv[k].ed);
    end

    do_reset();
    chk("async_reset", 16'h0000, 1'b0);
    release_reset();

    load4(16'h1000); cyc(1'b1, 4'd0, 1'b1, 1'b0); chk("borrow_10_00", 16'h0959, 1'b0);
    load4(16'h0100); cyc(1'b1, 4'd0, 1'b1, 1'b0); chk("borrow_01_00", 16'h0059, 1'b0);
    load4(16'h0090); cyc(1'b1, 4'd0, 1'b1, 1'b0); chk("tick_00_90", 16'h0089, 1'b0);
    load4(16'h0060); cyc(1'b1, 4'd0, 1'b1, 1'b0); chk("tick_00_60", 16'h0059, 1'b0);

    load4(16'h0002);
    cyc(1'b1, 4'd0, 1'b1, 1'b0); chk("term_00_01", 16'h0001, 1'b0);
    cyc(1'b1, 4'd0, 1'b1, 1'b0); chk("term_done", 16'h0000, 1'b1);
    cyc(1'b1, 4'd0, 1'b0, 1'b0); chk("term_done_fall", 16'h0000, 1'b0);
    for (int k = 0; k < 5; k++) begin
      cyc(1'b1, 4'd0, 1'b1, 1'b0);
      chk($sformatf("saturate%0d", k), 16'h0000, 1'b0);
    end
    load4(16'h0000); chk("entry_zero_no_done", 16'h0000, 1'b0);

    load4(16'h0010); cyc(1'b0, 4'd7, 1'b1, 1'b0); chk("arb_tick_wins", 16'h0009, 1'b0);
    load4(16'h0010); cyc(1'b0, 4'd3, 1'b1, 1'b1); chk("arb_entry_wins", 16'h0103, 1'b0);

    load4(16'h0005);
    cyc(1'b1, 4'd0, 1'b1, 1'b0);
    cyc(1'b1, 4'd0, 1'b1, 1'b0); chk("midcount_00_03", 16'h0003, 1'b0);
    do_reset();
    chk("midcount_reset", 16'h0000, 1'b0);
    release_reset();
    chk("midcount_no_done", 16'h0000, 1'b0);
    for (int k = 0; k < 3; k++) begin
      cyc(1'b1, 4'd0, 1'b1, 1'b0);
      chk($sformatf("post_reset_tick%0d", k), 16'h0000, 1'b0);
    end

    mm = 0; ss = 0;
    for (int k = 0; k < 3000; k++) begin
      ld = ($urandom_range(0, 4) != 0);
      dd = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 2));
      tk = $urandom_range(0, 1);
      en = ($urandom_range(0, 9) < 3);
      cyc(ld, dd, tk, en);
      m_step(ld, dd, tk, en);
      chk($sformatf("rand%0d", k), m_val(), m_done);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
